// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor helper used when sizing baud generators.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int DIV_MIN         = 2;

    // Clocks per oversample tick, rounded to nearest (50 MHz / 9600 baud -> 326).
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        int unsigned den;
        den = baud * UART_OVERSAMPLE;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/baud_div_ctr.sv
// Clock divider for the baud generator: owns the active/pending divisor pair and
// the period counter, and flags the raw oversample event. BAUD_FRAC_EN adds a fractional accumulator.
module baud_div_ctr
    import uart_pkg::*;
#(
    parameter int DIV_W       = 17,
    parameter int DEFAULT_DIV = 326
`ifdef BAUD_FRAC_EN
    ,
    parameter int FRAC_W      = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    input  logic             resync,
    output logic             os_evt
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_p;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] last;
    logic             pend;
    logic             wrap;
    logic             boundary;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : d;
    endfunction

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] frac_p;
    logic [FRAC_W-1:0] acc;
    logic              stretch;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac_q};
    // A carry out of the accumulator lengthens the following period by one clock.
    assign last    = div_q - DIV_W'(1) + DIV_W'(stretch);

    always_ff @(posedge clk) begin
        if (rst) begin
            frac_q  <= '0;
            frac_p  <= '0;
            acc     <= '0;
            stretch <= 1'b0;
        end else begin
            if (boundary && pend)
                frac_q <= frac_p;
            if (div_ld)
                frac_p <= frac_in;
            if (resync) begin
                acc     <= '0;
                stretch <= 1'b0;
            end else if (wrap) begin
                {stretch, acc} <= acc_sum;
            end
        end
    end
`else
    assign last = div_q - DIV_W'(1);
`endif

    // resync outranks a wrap landing in the same cycle, so no event fires then.
    assign wrap     = en && !resync && (div_cnt == last);
    assign boundary = resync || wrap;
    assign os_evt   = wrap;

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (resync || wrap)
            div_cnt <= '0;
        else if (en)
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // A load coinciding with a boundary stays pending until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_RST;
            div_p <= DIV_RST;
            pend  <= 1'b0;
        end else begin
            if (boundary && pend)
                div_q <= div_p;
            if (div_ld) begin
                div_p <= clamp_div(div_in);
                pend  <= 1'b1;
            end else if (boundary) begin
                pend  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud generator: oversample tick, bit tick and square-wave bclk from a
// programmable divisor. Define BAUD_FRAC_EN for fractional division (adds FRAC_W, frac_in).
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W       = 17,
    parameter int DEFAULT_DIV = 326,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE
`ifdef BAUD_FRAC_EN
    ,
    parameter int FRAC_W      = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    input  logic             resync,
    output logic             os_tick,
    output logic             bit_tick,
    output logic             bclk
);

    // OVERSAMPLE must be even and at least 2 so the mid-bit point is a whole tick.
    localparam int              OS_W       = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_PRE_MID = OS_W'(OVERSAMPLE / 2 - 1);

    logic            os_evt;
    logic [OS_W-1:0] os_cnt;

    baud_div_ctr #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
`ifdef BAUD_FRAC_EN
        ,
        .FRAC_W      (FRAC_W)
`endif
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_ld  (div_ld),
        .div_in  (div_in),
`ifdef BAUD_FRAC_EN
        .frac_in (frac_in),
`endif
        .resync  (resync),
        .os_evt  (os_evt)
    );

    // bclk rises with bit_tick and falls when os_cnt reaches the mid-bit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            bclk     <= 1'b0;
        end else if (resync) begin
            os_cnt   <= OS_MID;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            bclk     <= 1'b0;
        end else begin
            os_tick  <= os_evt;
            bit_tick <= os_evt && (os_cnt == OS_LAST);
            if (os_evt) begin
                if (os_cnt == OS_LAST) begin
                    os_cnt <= '0;
                    bclk   <= 1'b1;
                end else begin
                    os_cnt <= os_cnt + OS_W'(1);
                    if (os_cnt == OS_PRE_MID)
                        bclk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen with DEFAULT_DIV=4, OVERSAMPLE=4; expected
// tick cycles and bclk levels are hand-derived tables queued per phase.
module tb_baud_tick_gen;

    typedef struct packed { int c; int v; } lvl_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        en     = 1'b1;
    logic        div_ld = 1'b0;
    logic        resync = 1'b0;
    logic [16:0] div_in = '0;
`ifdef BAUD_FRAC_EN
    logic [3:0]  frac_in = '0;
    localparam int END_CYC = 262;
`else
    localparam int END_CYC = 172;
`endif
    logic        os_tick;
    logic        bit_tick;
    logic        bclk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    int   os_q[$];
    int   bit_q[$];
    lvl_t bclk_q[$];

    // Cycle numbers count rising edges; a value is seen at the falling edge after that rising edge.
    int os_tab[$] = '{7, 11, 15, 19, 23, 27, 31, 35, 39, 43,
                      47, 53, 59, 65, 71, 77, 83,
                      90, 94, 98, 102, 106, 110,
                      114, 116, 118, 120, 122, 129, 131, 133, 135, 137, 139,
                      145, 149, 153, 157, 161, 165, 169};
    int bit_tab[$] = '{19, 35, 53, 77, 94, 110, 120, 133, 157};
    lvl_t bclk_tab[$] = '{'{3, 0}, '{18, 0}, '{19, 1}, '{26, 1}, '{27, 0}, '{34, 0}, '{35, 1},
                          '{42, 1}, '{43, 0}, '{52, 0}, '{53, 1}, '{64, 1}, '{65, 0}, '{76, 0},
                          '{77, 1}, '{85, 1}, '{86, 0}, '{93, 0}, '{94, 1}, '{101, 1}, '{102, 0},
                          '{109, 0}, '{110, 1}, '{115, 1}, '{116, 0}, '{119, 0}, '{120, 1},
                          '{125, 1}, '{128, 1}, '{129, 0}, '{132, 0}, '{133, 1}, '{136, 1},
                          '{137, 0}, '{141, 0}, '{156, 0}, '{157, 1}, '{164, 1}, '{165, 0}};
`ifdef BAUD_FRAC_EN
    int os_frac[$] = '{173, 181, 185, 190, 194, 199, 203, 208, 212, 217,
                       221, 226, 230, 235, 239, 244, 248, 253, 257};
    int bit_frac[$] = '{173, 185, 203, 221, 239, 257};
`endif

    baud_tick_gen #(
        .DIV_W       (17),
        .DEFAULT_DIV (4),
        .OVERSAMPLE  (4)
`ifdef BAUD_FRAC_EN
        ,
        .FRAC_W      (4)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_ld   (div_ld),
        .div_in   (div_in),
`ifdef BAUD_FRAC_EN
        .frac_in  (frac_in),
`endif
        .resync   (resync),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .bclk     (bclk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic load_exp(input int lo, input int hi);
        foreach (os_tab[i])   if (os_tab[i] >= lo && os_tab[i] <= hi) os_q.push_back(os_tab[i]);
        foreach (bit_tab[i])  if (bit_tab[i] >= lo && bit_tab[i] <= hi) bit_q.push_back(bit_tab[i]);
        foreach (bclk_tab[i]) if (bclk_tab[i].c >= lo && bclk_tab[i].c <= hi) bclk_q.push_back(bclk_tab[i]);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every observed tick must match the head of its queue; overdue heads are missed ticks.
    always @(negedge clk) begin
        int nxt;
        while (os_q.size() > 0 && os_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL os_tick missing: required at cycle %0d, absent through cycle %0d", os_q[0], cyc);
            void'(os_q.pop_front());
        end
        while (bit_q.size() > 0 && bit_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL bit_tick missing: required at cycle %0d, absent through cycle %0d", bit_q[0], cyc);
            void'(bit_q.pop_front());
        end
        if (os_tick === 1'b1) begin
            checks++;
            nxt = (os_q.size() > 0) ? os_q[0] : -1;
            if (nxt == cyc) void'(os_q.pop_front());
            else begin
                errors++;
                $display("FAIL os_tick timing: seen at cycle %0d, next required %0d", cyc, nxt);
            end
        end
        if (bit_tick === 1'b1) begin
            checks++;
            nxt = (bit_q.size() > 0) ? bit_q[0] : -1;
            if (nxt == cyc) void'(bit_q.pop_front());
            else begin
                errors++;
                $display("FAIL bit_tick timing: seen at cycle %0d, next required %0d", cyc, nxt);
            end
        end
        while (bclk_q.size() > 0 && bclk_q[0].c <= cyc) begin
            checks++;
            if (bclk_q[0].c != cyc || bclk !== bclk_q[0].v[0]) begin
                errors++;
                $display("FAIL bclk level: cycle %0d got %b, required %0d at cycle %0d",
                         cyc, bclk, bclk_q[0].v, bclk_q[0].c);
            end
            void'(bclk_q.pop_front());
        end
    end

    initial begin
        int left;
        // Reset, then free-run at the default divisor.
        load_exp(0, 43);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(43);
        load_exp(44, 85);
        // Reload to 6 while the current period is one clock in.
        wait_cyc(44);
        div_in = 17'd6; div_ld = 1'b1;
        wait_cyc(45);
        div_ld = 1'b0;
        // Queue a divisor of 4, then resync mid-bit; resync applies it at once.
        wait_cyc(84);
        div_in = 17'd4; div_ld = 1'b1;
        wait_cyc(85);
        div_ld = 1'b0;
        load_exp(86, 110);
        resync = 1'b1;
        wait_cyc(86);
        resync = 1'b0;
        // Divisor 0 clamps to 2; then hold en low for 5 clocks.
        wait_cyc(110);
        load_exp(111, 140);
        div_in = 17'd0; div_ld = 1'b1;
        wait_cyc(111);
        div_ld = 1'b0;
        wait_cyc(122);
        en = 1'b0;
        wait_cyc(127);
        en = 1'b1;
        // Reset with a pending divisor and os_cnt at 3.
        wait_cyc(139);
        div_in = 17'd7; div_ld = 1'b1;
        wait_cyc(140);
        div_ld = 1'b0;
        load_exp(141, 170);
        rst = 1'b1;
        wait_cyc(141);
        rst = 1'b0;
`ifdef BAUD_FRAC_EN
        // Divisor 4 with half-clock fraction: steady-state gaps alternate 4/5.
        wait_cyc(170);
        foreach (os_frac[i])  os_q.push_back(os_frac[i]);
        foreach (bit_frac[i]) bit_q.push_back(bit_frac[i]);
        wait_cyc(175);
        div_in = 17'd4; frac_in = 4'd8; div_ld = 1'b1;
        wait_cyc(176);
        div_ld = 1'b0; resync = 1'b1;
        wait_cyc(177);
        resync = 1'b0;
`endif
        wait_cyc(END_CYC);
        left = os_q.size() + bit_q.size() + bclk_q.size();
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d expectations left, required 0", left);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised baud-rate generator for the UART controller.
- Produces three outputs from a runtime-programmable divisor:
  - os_tick: an oversample tick for the RX sampler.
  - bit_tick: a bit-rate tick for the TX shifter.
  - bclk: a square-wave baud clock that stays compatible with existing bclk users.
- Supports enable, a divisor change that takes effect glitch-free at a period boundary, and phase resync so RX can align to a start-bit edge.

Parameters:
- DIV_W, 17: width of the divisor and the clock-divider counter.
- DEFAULT_DIV, 326: divisor after reset, in clocks per os_tick (50 MHz / (9600*16)).
- OVERSAMPLE, 16: os_ticks per bit. Must be even and >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable. When low, all counters hold.
- div_ld  in  1  one-cycle strobe that captures div_in into the pending register.
- div_in  in  DIV_W  new divisor in clocks per os_tick.
- resync  in  1  one-cycle strobe that restarts phase at mid-bit.
- os_tick  out  1  one-cycle pulse every div_q clocks.
- bit_tick  out  1  one-cycle pulse every OVERSAMPLE os_ticks.
- bclk  out  1  baud square wave: high for the first half of the bit, low for the second half.

Behaviour:
- Internal state:
  - div_q: active divisor.
  - div_p: pending divisor.
  - pend: flag indicating div_p holds an unapplied value.
  - div_cnt: counts 0..div_q-1.
  - os_cnt: counts 0..OVERSAMPLE-1, width $clog2(OVERSAMPLE).
- Reset (rst=1 on a clk edge) sets:
  - div_q = div_p = DEFAULT_DIV, pend = 0.
  - div_cnt = 0, os_cnt = 0.
  - os_tick = bit_tick = bclk = 0.
- All outputs are registered. Ticks are high for exactly one cycle.
- Each enabled cycle, div_cnt increments.
  - When div_cnt == div_q-1, div_cnt wraps to 0 and os_tick is 1 on the next cycle.
  - First os_tick after reset release falls div_q cycles after the first enabled edge.
- On each os_tick event, os_cnt increments.
  - When os_cnt == OVERSAMPLE-1, os_cnt wraps to 0, bit_tick fires in the same cycle as os_tick, and bclk goes 1.
  - When os_cnt advances to OVERSAMPLE/2, bclk goes 0.
- div_ld:
  - Writes div_p = div_in and sets pend = 1. A later div_ld overwrites the pending value.
  - The pending value is applied (div_q = div_p, pend = 0) only at a div_cnt wrap or on resync, never mid-period.
- Divisor clamp: div_in < 2 is stored as 2, so the minimum os_tick period is 2 clocks.
- resync:
  - Sets div_cnt = 0 and os_cnt = OVERSAMPLE/2, and applies any pending divisor.
  - bclk goes 0 and no tick fires that cycle.
  - The next bit_tick follows after OVERSAMPLE/2 os_ticks (mid-bit).
- en = 0:
  - div_cnt, os_cnt and bclk hold, and ticks are 0.
  - div_ld and resync are still honoured.
- Priority within one cycle: rst > resync > divisor wrap > div_ld capture. div_ld in the same cycle as a wrap is captured but applied at the following boundary.
- Reset mid-period discards pend and the partial count, with no spurious tick.

Optional Feature:
- Macro BAUD_FRAC_EN adds fractional division.
  - New parameter FRAC_W, default 4.
  - New port frac_in (in, FRAC_W bits), captured with div_ld/div_in into the pending and active pair.
  - A FRAC_W-bit accumulator acc (reset 0, cleared on resync) adds frac_q on each os_tick.
  - When that add carries out, the next os period is div_q+1 clocks.
  - Average period is div_q + frac_q/2^FRAC_W.
- Without the macro, there is no frac_in port or accumulator, and the period is exactly div_q.

Decomposition:
- Package uart_pkg holds:
  - Constant UART_OVERSAMPLE = 16.
  - Function baud_div(clk_hz, baud) returning the integer divisor.
  - Constant DIV_MIN = 2.
- One sub-module, baud_div_ctr. It owns div_cnt, div_q/div_p/pend and (under the macro) acc, and emits the raw os event.
- The top level wraps baud_div_ctr with the os_cnt, bit_tick and bclk logic.

Test Plan:
- Reset value: DEFAULT_DIV=4, OVERSAMPLE=4, en=1.
  - Expect os_tick every 4 cycles and bit_tick every 16 cycles.
  - Expect bclk high 8 cycles, low 8 cycles.
  - First os_tick at cycle 4 after reset release.
- Mid-period reload: div_ld with div_in=6 at div_cnt=1.
  - The current period still completes in 4 clocks.
  - Following os_tick gaps are 6. No short or long period occurs.
- Resync: pulse resync mid-bit.
  - Next bit_tick occurs exactly 2 os_ticks (8 clocks) later.
  - bclk is 0 until that bit_tick.
- Clamp and enable: div_in=0 gives os_tick every 2 cycles. Dropping en for 5 cycles extends the gap to 7 with no tick while en=0.
- Reset mid-operation: assert rst for 1 cycle while pend=1 and os_cnt=3.
  - All outputs are 0 the next cycle.
  - Period reverts to DEFAULT_DIV.
- BAUD_FRAC_EN: div=4, frac_in=8 with FRAC_W=4.
  - os_tick gaps alternate 4,5,4,5.
  - 16 os_ticks take 72 clocks.
